// File: rtl/dual_port_ram_pkg.sv
// Purpose     : shared encodings for the dual-port RAM read/write sequencers.
// Latency     : n/a (constants only).
// Backpressure: n/a.
// Contents: state encoding for the burst sequencer FSMs.
package dual_port_ram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/wrap_addr_counter.sv
// Purpose     : address counter that wraps modulo 2**width, with parallel load.
// Latency     : value updates one cycle after load/inc.
// Backpressure: none; caller gates inc.
// Ports: clk, reset_n (sync, active-low), load + load_value, inc, value.
// load has priority over inc.
module wrap_addr_counter #(
  parameter int width = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  input  logic [width-1:0] load_value,
  output logic [width-1:0] value
);

  logic [width-1:0] value_d;
  logic [width-1:0] value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (inc) begin
      // Natural overflow of the width-bit adder gives the modulo wrap.
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/dual_port_ram_burst_reader.sv
// Purpose     : walks the RAM read port for burst_len words from start_addr onto a registered stream.
// Latency     : start accepted at edge N, first beat valid after edge N+1; one beat/cycle with m_ready high.
// Backpressure: m_valid & !m_ready holds m_data/m_last and the address; start while busy is ignored.
// Ports: clk, reset_n (sync, active-low); start/start_addr/burst_len request; addr_rd/ram_dout RAM read port;
//        m_data/m_valid/m_ready/m_last stream; busy (state != IDLE); done (one-cycle completion pulse).
// Optional: define BURST_READER_PARITY_EN to add m_parity (XOR of the loaded word, registered with m_data).
module dual_port_ram_burst_reader
  import dual_port_ram_pkg::*;
#(
  parameter int addr_width = 2,
  parameter int data_width = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [addr_width-1:0] start_addr,
  input  logic [addr_width:0]   burst_len,
  output logic [addr_width-1:0] addr_rd,
  input  logic [data_width-1:0] ram_dout,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
`ifdef BURST_READER_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  localparam logic [addr_width:0] CNT_ONE = 1;

  state_t state_q, state_d;
  logic [addr_width:0]   count_q, count_d;
  logic [data_width-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  done_q, done_d;
  logic                  parity_q, parity_d;
  logic                  addr_load, addr_inc;

  // The output register can take a new word when it is empty or being drained.
  logic load_beat;
  assign load_beat = (state_q == ST_READ) && (!m_valid_q || m_ready);

  wrap_addr_counter #(.width(addr_width)) u_addr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (addr_load),
    .inc       (addr_inc),
    .load_value(start_addr),
    .value     (addr_rd)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      parity_q  <= parity_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && (burst_len != '0)) state_d = ST_READ;
      ST_READ:  if (load_beat && (count_q == CNT_ONE)) state_d = ST_FLUSH;
      ST_FLUSH: if (m_valid_q && m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    count_d   = count_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            addr_load = 1'b1;
            count_d   = burst_len;
          end else begin
            // Zero-length burst completes immediately without a beat.
            done_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (load_beat) begin
          m_data_d  = ram_dout;
          parity_d  = ^ram_dout;
          m_valid_d = 1'b1;
          m_last_d  = (count_q == CNT_ONE);
          addr_inc  = 1'b1;
          count_d   = count_q - 1'b1;
        end
      end
      ST_FLUSH: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

`ifdef BURST_READER_PARITY_EN
  assign m_parity = parity_q;
`else
  logic unused_parity;
  assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_burst_reader.sv
// Purpose     : self-checking bench for dual_port_ram_burst_reader with a RAM model on its read port.
// Latency     : checks first-beat timing, L+1 cycles to last acceptance, one-cycle done pulse.
// Backpressure: drives m_ready patterns and checks data/last stability while stalled.
module tb_dual_port_ram_burst_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] start_addr;
  logic [2:0] burst_len;
  logic [1:0] addr_rd;
  logic [2:0] ram_dout;
  logic [2:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic       done;
`ifdef BURST_READER_PARITY_EN
  logic       m_parity;
`endif

  always #5 clk = ~clk;

  // Asynchronous-read RAM model, preloaded {0:5,1:2,2:7,3:1}.
  logic [2:0] mem [4];
  initial begin
    mem[0] = 3'd5; mem[1] = 3'd2; mem[2] = 3'd7; mem[3] = 3'd1;
  end
  assign ram_dout = mem[addr_rd];

  dual_port_ram_burst_reader #(.addr_width(2), .data_width(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .burst_len (burst_len),
    .addr_rd   (addr_rd),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
`ifdef BURST_READER_PARITY_EN
    ,
    .m_parity  (m_parity)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0] data;
    logic       last;
    logic       par;
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic l, input logic p);
    beat_t b;
    b.data = d; b.last = l; b.par = p;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each accepted beat, checks stall stability.
  logic       stalled = 1'b0;
  logic [2:0] held_data;
  logic       held_last;

  always @(negedge clk) begin
    beat_t b;
    if (reset_n === 1'b1) begin
      if (stalled && m_valid) begin
        chk("stall_data", m_data, held_data);
        chk("stall_last", m_last, held_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_data, 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", m_data, b.data);
          chk("beat_last", m_last, b.last);
`ifdef BURST_READER_PARITY_EN
          chk("beat_parity", m_parity, b.par);
`endif
        end
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
    end else begin
      stalled = 1'b0;
    end
  end

  // Issues one burst; pat[k] is m_ready for the k-th edge after the start edge.
  // exp_cyc < 0 skips the latency check.
  task automatic burst(input logic [1:0] sa, input logic [2:0] len, input logic [15:0] pat,
                       input int exp_cyc, input string nm);
    int k;
    start = 1'b1; start_addr = sa; burst_len = len; m_ready = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_busy_after_start"}, busy, (len != 0));
    if (len != 0) chk({nm, "_addr_start"}, addr_rd, sa);
    k = 0;
    while (!done && k < 30) begin
      m_ready = (k < 16) ? pat[k] : 1'b1;
      tick();
      k++;
    end
    if (!done) begin
      chk({nm, "_done_timeout"}, 0, 1);
    end else if (exp_cyc >= 0) begin
      chk({nm, "_done_latency"}, k, exp_cyc);
    end
    m_ready = 1'b1;
    tick();
    chk({nm, "_done_pulse_width"}, done, 0);
    chk({nm, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; m_ready = 1'b1;
    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_rd", addr_rd, 0);
`ifdef BURST_READER_PARITY_EN
    chk("rst_parity", m_parity, 0);
`endif
    reset_n = 1'b1;
    tick();

    // Full burst from 0: 5,2,7,1; parity 0,1,1,1.
    push(3'd5, 1'b0, 1'b0); push(3'd2, 1'b0, 1'b1);
    push(3'd7, 1'b0, 1'b1); push(3'd1, 1'b1, 1'b1);
    burst(2'd0, 3'd4, 16'hFFFF, 5, "len4");

    // Wrap: addresses 3,0,1 -> 1,5,2.
    push(3'd1, 1'b0, 1'b1); push(3'd5, 1'b0, 1'b0); push(3'd2, 1'b1, 1'b1);
    burst(2'd3, 3'd3, 16'hFFFF, 4, "wrap");

    // Backpressure: beats 2,7,1 with stalls in between.
    push(3'd2, 1'b0, 1'b1); push(3'd7, 1'b0, 1'b1); push(3'd1, 1'b1, 1'b1);
    burst(2'd1, 3'd3, 16'hFFD3, -1, "stall");

    // Zero-length burst: done next cycle, no beat, busy low.
    burst(2'd2, 3'd0, 16'hFFFF, 0, "zero");

    // Reset mid-burst after the second beat is accepted.
    push(3'd5, 1'b0, 1'b0); push(3'd2, 1'b0, 1'b1);
    start = 1'b1; start_addr = 2'd0; burst_len = 3'd4; m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    m_ready = 1'b0; reset_n = 1'b0;
    tick();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_m_last", m_last, 0);
    chk("midrst_addr_rd", addr_rd, 0);
    reset_n = 1'b1; m_ready = 1'b1;
    tick();
    chk("midrst_no_done", done, 0);

    // Single beat after reset: 7 with m_last.
    push(3'd7, 1'b1, 1'b1);
    burst(2'd2, 3'd1, 16'hFFFF, 2, "single");

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_burst_reader.md
Name: dual_port_ram_burst_reader

Overview:
Read-side sequencer for the dual-port RAM. On a start request it walks the RAM read port from a start address for a programmed number of words. It presents each word on a registered valid/ready stream. Sits between the RAM's read port and any downstream consumer (UART transmitter, display driver, checker).

Parameters:
addr_width, 2, RAM address bits; RAM depth = 2**addr_width
data_width, 3, bits per RAM word

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  burst request, sampled only in IDLE
start_addr  input  addr_width  first RAM address of burst
burst_len  input  addr_width+1  words to read, 0..2**addr_width
addr_rd  output  addr_width  drives RAM read address
ram_dout  input  data_width  RAM asynchronous read data for addr_rd
m_data  output  data_width  stream data (registered)
m_valid  output  1  stream data valid
m_ready  input  1  consumer accepts beat when m_valid & m_ready
m_last  output  1  marks final beat of burst
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after last beat accepted or zero-length burst

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, reset_n.
- Reset (reset_n=0 at rising edge):
  - state=IDLE; addr_rd=0; m_data=0; m_valid=0; m_last=0; busy=0; done=0; remaining count=0.
  - Reset mid-burst abandons the burst; no done pulse.
- States: IDLE, READ, FLUSH.
- IDLE:
  - start=1, burst_len>0: latch addr_rd<=start_addr, count<=burst_len, go to READ.
  - start=1, burst_len=0: done=1 next cycle, stay IDLE, no beat emitted.
  - start=0: stay IDLE.
- READ, load condition: (!m_valid) | m_ready.
  - When load condition holds: m_data<=ram_dout; m_valid<=1; m_last<=(count==1); addr_rd<=addr_rd+1 mod 2**addr_width; count<=count-1.
  - If count==1 at that load, go to FLUSH.
  - When load condition is false, hold all registers.
- FLUSH: hold until m_valid & m_ready. Then m_valid<=0, m_last<=0, done<=1 for one cycle, go to IDLE.
- Latency: start accepted at edge N; first beat has m_valid=1 after edge N+1.
- Throughput: with m_ready held high, one beat per cycle. A burst of L takes L+1 cycles from start to the last beat accepted; done is high in the following cycle.
- m_data/m_last stability: must not change while m_valid=1 and m_ready=0.
- Wrap: addresses wrap modulo depth. start_addr=3, len=3 reads 3,0,1.
- burst_len > 2**addr_width: behaviour undefined; the bench must not drive it.
- start while busy: ignored, no queuing.
- The block never writes the RAM. Concurrent writes to the address being read return the RAM's current combinational value at the load edge.

Optional Feature:
Macro BURST_READER_PARITY_EN.
- Defined: adds output m_parity (1 bit) = XOR of the bits loaded into m_data. It is registered in the same edge as m_data and reset to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package dual_port_ram_pkg: state encoding constants ST_IDLE=2'd0, ST_READ=2'd1, ST_FLUSH=2'd2.
- A sub-module wrap_addr_counter (load, inc, value; width addr_width) is natural and reusable by the write-side sequencer.
- Bench instantiates dual_port_RAM alongside to close the loop.

Test Plan:
RAM preloaded {0:5,1:2,2:7,3:1}. start_addr=0, burst_len=4, m_ready=1 -> m_data 5,2,7,1 on consecutive cycles; m_last only on 1; done pulse one cycle after.
start_addr=3, burst_len=3, m_ready=1 -> addr_rd 3,0,1; m_data 1,5,2; m_last on 2.
start_addr=1, burst_len=3, m_ready toggled 1,0,0,1,0,1 -> beats 2,7,1 delivered in order; m_data held stable while stalled; no duplicates or drops.
burst_len=0 with start=1 -> no m_valid; done=1 exactly one cycle later; busy stays 0.
reset_n=0 driven for one cycle mid-burst after second beat of len=4 -> m_valid, busy, done =0 next cycle; new start_addr=2, len=1 then yields single beat 7 with m_last=1.
BURST_READER_PARITY_EN defined, burst 5,2,7,1 -> m_parity 0,1,1,1.
